switch_input_capture: RTL and testbench

- Input-side counterpart to the result display path: takes a value from the board slide switches into the processor instead of driving a result out to the 7-segment digits.
- A 2-FF synchronizer feeds a debounce FSM on the "enter" push-button. On each debounced press the block captures the switch word, zero-extends it to 32 bits and holds it for the core.
- The core consumes the word with a valid/read-strobe handshake. Overrun and press counting are included for debug.

---
 rtl/switch_input_capture.sv | 140 ++++++++++++++
 tb/tb_switch_input_capture.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/switch_input_capture.sv
// Slide-switch capture for the core: a debounced "enter" press latches the synchronized
// switch word, zero-extended to 32 bits, behind a valid/read-strobe handshake.

module switch_input_capture_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module switch_input_capture #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SW_WIDTH        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SW_WIDTH-1:0] sw,
  input  logic                btn_enter,
  input  logic                rd_en,
  output logic [31:0]         data_out,
  output logic                data_valid,
  output logic                overrun,
  output logic [7:0]          press_cnt,
  output logic                btn_state
);
  localparam logic [31:0] CNT_MAX = 32'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  logic [SW_WIDTH-1:0] sw_s;
  logic                btn_s;

  // One 2-flop cell per switch bit plus one for the button.
  genvar g;
  generate
    for (g = 0; g < SW_WIDTH; g++) begin : g_sw_sync
      switch_input_capture_sync u_sync (.clk(clk), .rst(rst), .d(sw[g]), .q(sw_s[g]));
    end
  endgenerate

  switch_input_capture_sync u_btn_sync (.clk(clk), .rst(rst), .d(btn_enter), .q(btn_s));

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic        capture;
  logic [31:0] data_out_n;
  logic        data_valid_n, overrun_n;
  logic [7:0]  press_cnt_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      press_cnt  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      data_out   <= data_out_n;
      data_valid <= data_valid_n;
      overrun    <= overrun_n;
      press_cnt  <= press_cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_n = PRESS_WAIT;
          cnt_n   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_n = IDLE;
        end else if (cnt == CNT_MAX) begin
          state_n = PRESSED;
          capture = 1'b1;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_n = RELEASE_WAIT;
          cnt_n   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_n = PRESSED;
        end else if (cnt == CNT_MAX) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A capture beats a same-cycle read: the old word counts as read, so overrun
  // only sets when the previous word was still pending and unread.
  always_comb begin
    data_out_n   = data_out;
    data_valid_n = data_valid;
    overrun_n    = overrun;
    press_cnt_n  = press_cnt;
    if (capture) begin
      data_out_n   = 32'(sw_s);
      data_valid_n = 1'b1;
      press_cnt_n  = press_cnt + 8'd1;
      if (data_valid) overrun_n = !rd_en;
    end else if (rd_en && data_valid) begin
      data_valid_n = 1'b0;
      overrun_n    = 1'b0;
    end
  end

  assign btn_state = (state == PRESSED) || (state == RELEASE_WAIT);

endmodule

// File: tb/tb_switch_input_capture.sv
// Scoreboarded bench: each accepted press pushes its expected word/count; the monitor
// pops and compares whenever press_cnt steps.

module tb_switch_input_capture;
  localparam int D  = 4;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [SW-1:0] sw = '0;
  logic          btn_enter = 1'b0;
  logic          rd_en = 1'b0;
  logic [31:0]   data_out;
  logic          data_valid, overrun, btn_state;
  logic [7:0]    press_cnt;

  switch_input_capture #(.DEBOUNCE_CYCLES(D), .SW_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_enter(btn_enter), .rd_en(rd_en),
    .data_out(data_out), .data_valid(data_valid), .overrun(overrun),
    .press_cnt(press_cnt), .btn_state(btn_state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  logic [39:0] sb_q[$];   // {press_cnt, data_out}
  logic [7:0]  exp_cnt = '0;
  logic [7:0]  prev_cnt = '0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_cnt = '0;
    end else if (press_cnt !== prev_cnt) begin
      chk("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        logic [39:0] e;
        e = sb_q.pop_front();
        chk("sb_data", data_out, e[31:0]);
        chk("sb_cnt", 32'(press_cnt), 32'(e[39:32]));
      end
      prev_cnt = press_cnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_press(input logic [SW-1:0] w);
    exp_cnt = exp_cnt + 8'd1;
    sb_q.push_back({exp_cnt, 32'(w)});
  endtask

  task automatic press(input logic [SW-1:0] w);
    push_press(w);
    sw = w;
    btn_enter = 1'b1;
    repeat (D + 4) tick();
    btn_enter = 1'b0;
    repeat (D + 6) tick();
  endtask

  task automatic read_pulse();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dout"}, data_out, 32'd0);
    chk({tag, "_dv"}, 32'(data_valid), 32'd0);
    chk({tag, "_ov"}, 32'(overrun), 32'd0);
    chk({tag, "_pc"}, 32'(press_cnt), 32'd0);
    chk({tag, "_bs"}, 32'(btn_state), 32'd0);
  endtask

  // Drives the button high (rst must already be released) and checks the exact latency.
  task automatic latency_press(input string tag, input logic [SW-1:0] w);
    push_press(w);
    sw = w;
    btn_enter = 1'b1;
    for (int i = 1; i <= D + 3; i++) begin
      tick();
      if (i == D + 2) chk({tag, "_early"}, 32'(data_valid), 32'd0);
    end
    chk({tag, "_dv"}, 32'(data_valid), 32'd1);
    chk({tag, "_dout"}, data_out, 32'(w));
    chk({tag, "_bs"}, 32'(btn_state), 32'd1);
  endtask

  initial begin
    logic [31:0] bounce;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_zero("rst");
    end

    // Single press with exact latency; holding yields one capture only.
    rst = 1'b1;
    latency_press("lat", 16'hA5C3);
    chk("lat_pc", 32'(press_cnt), 32'd1);
    repeat (2 * D) tick();
    chk("hold_pc", 32'(press_cnt), 32'd1);
    btn_enter = 1'b0;
    repeat (D + 6) tick();
    chk("rel_bs", 32'(btn_state), 32'd0);

    // Read handshake, then a stray read with nothing pending.
    read_pulse();
    chk("rd_dv", 32'(data_valid), 32'd0);
    chk("rd_dout", data_out, 32'h0000A5C3);
    read_pulse();
    chk("rd2_dv", 32'(data_valid), 32'd0);
    chk("rd2_dout", data_out, 32'h0000A5C3);
    chk("rd2_ov", 32'(overrun), 32'd0);

    // Bounce: only the final stable run of four samples captures.
    bounce = 32'b11111101011;   // bit j is sample j (LSB first)
    push_press(16'h1234);
    sw = 16'h1234;
    for (int j = 0; j < 11; j++) begin
      btn_enter = bounce[j];
      tick();
      chk("bnc_quiet", 32'(data_valid), 32'd0);
    end
    tick();
    chk("bnc_dv", 32'(data_valid), 32'd1);
    btn_enter = 1'b0;
    repeat (D + 6) tick();
    read_pulse();

    // Overrun on an unread word, cleared by the next read.
    press(16'h0001);
    chk("ov_first", 32'(overrun), 32'd0);
    press(16'h0002);
    chk("ov_dout", data_out, 32'h00000002);
    chk("ov_set", 32'(overrun), 32'd1);
    read_pulse();
    chk("ov_clr", 32'(overrun), 32'd0);
    chk("ov_dv", 32'(data_valid), 32'd0);

    // Capture coincident with a read: capture wins, overrun clears.
    press(16'h00AA);
    press(16'h00AB);
    chk("sim_pre_ov", 32'(overrun), 32'd1);
    push_press(16'h00BB);
    sw = 16'h00BB;
    btn_enter = 1'b1;
    repeat (D + 2) tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("sim_dv", 32'(data_valid), 32'd1);
    chk("sim_dout", data_out, 32'h000000BB);
    chk("sim_ov", 32'(overrun), 32'd0);
    repeat (D) tick();
    btn_enter = 1'b0;
    repeat (D + 6) tick();

    // Clean presses until the 8-bit count wraps back to zero (256 presses in total).
    for (int k = 0; exp_cnt != 8'd0; k++) press(SW'(k * 37));
    chk("wrap_pc", 32'(press_cnt), 32'd0);

    // Reset while in PRESS_WAIT, then full latency again with the button still high.
    sw = 16'h5555;
    btn_enter = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    exp_cnt = '0;
    repeat (2) tick();
    chk_zero("mid_rst");
    rst = 1'b1;
    latency_press("relat", 16'h5555);
    chk("relat_pc", 32'(press_cnt), 32'd1);
    btn_enter = 1'b0;
    repeat (D + 6) tick();

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
